// File: rtl/ltssm_pkg.sv
// ============================================================================
// Module  : ltssm_pkg
// Brief   : Shared constants, state type and slot-period helper for the
//           LTSSM ordered-set transmit scheduler.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ltssm_pkg;

  localparam logic [2:0] GEN1 = 3'd0;
  localparam logic [2:0] GEN2 = 3'd1;
  localparam logic [2:0] GEN3 = 3'd2;
  localparam logic [2:0] GEN4 = 3'd3;
  localparam logic [2:0] GEN5 = 3'd4;

  localparam int LANE_NUM_LSB = 48;

  // COM followed by SKP symbols in every remaining position
  localparam logic [127:0] SKP_OS_WORD = {{15{8'h1C}}, 8'hBC};

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } sched_state_t;

  // Clocks per OS slot; undefined rate codes fall back to the Gen1 pace
  function automatic logic [6:0] slot_period(input logic [2:0] rate);
    case (rate)
      GEN2:    return 7'd32;
      GEN3:    return 7'd16;
      GEN4:    return 7'd8;
      GEN5:    return 7'd4;
      default: return 7'd64;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/ltssm_slot_timer.sv
// ============================================================================
// Module  : ltssm_slot_timer
// Brief   : Per-generation slot down-counter; strobes o_issue when the
//           count reaches zero and reloads from the rate sampled then.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ltssm_slot_timer
  import ltssm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic       i_run,
  input  logic [2:0] i_rate,
  output logic       o_issue
);

  logic [5:0] r_slot_cnt;

  assign o_issue = i_run && (r_slot_cnt == 6'd0);

  // Reload happens on entry and on every issue cycle, so a rate change
  // only affects the slot after the one in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_slot_cnt <= '0;
    end else if (i_load || o_issue) begin
      r_slot_cnt <= 6'(slot_period(i_rate) - 7'd1);
    end else if (i_run) begin
      r_slot_cnt <= r_slot_cnt - 6'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ltssm_ts_tx_sched.sv
// ============================================================================
// Module  : ltssm_ts_tx_sched
// Brief   : Paces TS1/TS2 and SKP ordered sets onto the lanes at the slot
//           rate; optional SKP insertion enabled by LTSSM_TS_SKP_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ltssm_ts_tx_sched
  import ltssm_pkg::*;
#(
  parameter int NUM_LANES    = 4,
  parameter int TS_W         = 128,
  parameter int SKP_INTERVAL = 74,
  parameter int CNT_W        = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sched_en,
  input  logic [2:0]                rate,
  input  logic [NUM_LANES-1:0]      lane_en,
  input  logic                      lane_num_ins,
  input  logic [TS_W-1:0]           req_ts,
  input  logic                      req_vld,
  output logic                      req_rdy,
  output logic [NUM_LANES*TS_W-1:0] lane_ts_o,
  output logic [NUM_LANES-1:0]      lane_ts_o_vld,
  output logic [CNT_W-1:0]          ts_sent_cnt,
  input  logic                      ts_cnt_clr,
  output logic                      skp_sent
);

  sched_state_t r_state;
  sched_state_t w_state_nxt;

  logic w_load;
  logic w_run;
  logic w_issue;
  logic w_skp_issue;
  logic w_accept;
  logic w_emit;

  logic [NUM_LANES-1:0] r_lane_vld;
  logic [CNT_W-1:0]     r_ts_cnt;
  logic                 r_skp_sent;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_run       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (sched_en) begin
          w_state_nxt = ST_ACTIVE;
          w_load      = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (sched_en) begin
          w_run = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  ltssm_slot_timer u_slot_timer (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_run   (w_run),
    .i_rate  (rate),
    .o_issue (w_issue)
  );

`ifdef LTSSM_TS_SKP_EN
  localparam int SKP_W = (SKP_INTERVAL > 1) ? $clog2(SKP_INTERVAL) : 1;

  logic [SKP_W-1:0] r_skp_cnt;
  logic [SKP_W-1:0] w_skp_cnt_inc;
  logic             r_skp_pending;

  assign w_skp_cnt_inc = r_skp_cnt + SKP_W'(1);
  assign w_skp_issue   = w_issue & r_skp_pending;

  // Pending survives IDLE; a fresh request outranks clearing the old one
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_skp_cnt     <= '0;
      r_skp_pending <= 1'b0;
    end else if (w_issue) begin
      if (w_skp_cnt_inc == SKP_W'(SKP_INTERVAL - 1)) begin
        r_skp_cnt     <= '0;
        r_skp_pending <= 1'b1;
      end else begin
        r_skp_cnt <= w_skp_cnt_inc;
        if (w_skp_issue) begin
          r_skp_pending <= 1'b0;
        end
      end
    end
  end
`else
  logic [31:0] w_unused_skp_interval;

  assign w_unused_skp_interval = 32'(SKP_INTERVAL);
  assign w_skp_issue           = 1'b0;
`endif

  assign w_accept = w_issue & ~w_skp_issue & req_vld;
  assign w_emit   = w_accept | w_skp_issue;
  assign req_rdy  = w_accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lane_vld <= '0;
      r_skp_sent <= 1'b0;
    end else begin
      r_lane_vld <= w_emit ? lane_en : '0;
      r_skp_sent <= w_skp_issue;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ts_cnt <= '0;
    end else if (ts_cnt_clr) begin
      r_ts_cnt <= '0;
    end else if (w_accept && (r_ts_cnt != '1)) begin
      r_ts_cnt <= r_ts_cnt + CNT_W'(1);
    end
  end

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    logic [TS_W-1:0] w_word;
    logic [TS_W-1:0] r_ts;

    always_comb begin
      w_word = req_ts;
      if (lane_num_ins) begin
        w_word[LANE_NUM_LSB +: 8] = 8'(gi);
      end
      if (w_skp_issue) begin
        w_word = TS_W'(SKP_OS_WORD);
      end
    end

    // Disabled lanes keep their previous word
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_ts <= '0;
      end else if (w_emit && lane_en[gi]) begin
        r_ts <= w_word;
      end
    end

    assign lane_ts_o[gi*TS_W +: TS_W] = r_ts;
  end

  assign lane_ts_o_vld = r_lane_vld;
  assign ts_sent_cnt   = r_ts_cnt;
  assign skp_sent      = r_skp_sent;

endmodule

`default_nettype wire

// File: tb/tb_ltssm_ts_tx_sched.sv
// ============================================================================
// Module  : tb_ltssm_ts_tx_sched
// Brief   : Table vectors, directed corner sequences and a randomized run
//           against a time-based reference model (LTSSM_TS_SKP_EN aware).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ltssm_ts_tx_sched;

  localparam int NL   = 4;
  localparam int TW   = 128;
  localparam int SKPI = 4;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            sched_en = 1'b0;
  logic [2:0]      rate = 3'd0;
  logic [NL-1:0]   lane_en = '0;
  logic            lane_num_ins = 1'b0;
  logic [TW-1:0]   req_ts = '0;
  logic            req_vld = 1'b0;
  logic            ts_cnt_clr = 1'b0;
  logic            req_rdy;
  logic [NL*TW-1:0] lane_ts_o;
  logic [NL-1:0]   lane_ts_o_vld;
  logic [CW-1:0]   ts_sent_cnt;
  logic            skp_sent;

  int total = 0;
  int bad   = 0;

  logic [TW-1:0] exp_lane [NL];
  int            exp_cnt;

  logic [127:0] skp_word;

  typedef struct {
    logic [2:0]  rate;
    logic [3:0]  len;
    logic        lni;
    logic [31:0] seed;
    int          gap;
    logic [3:0]  vld;
  } vec_t;

  vec_t tv [8];

  ltssm_ts_tx_sched #(
    .NUM_LANES    (NL),
    .TS_W         (TW),
    .SKP_INTERVAL (SKPI),
    .CNT_W        (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sched_en      (sched_en),
    .rate          (rate),
    .lane_en       (lane_en),
    .lane_num_ins  (lane_num_ins),
    .req_ts        (req_ts),
    .req_vld       (req_vld),
    .req_rdy       (req_rdy),
    .lane_ts_o     (lane_ts_o),
    .lane_ts_o_vld (lane_ts_o_vld),
    .ts_sent_cnt   (ts_sent_cnt),
    .ts_cnt_clr    (ts_cnt_clr),
    .skp_sent      (skp_sent)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int period_of(input logic [2:0] r);
    if (r > 3'd4) return 64;
    return 64 / (1 << r);
  endfunction

  function automatic logic [TW-1:0] lane_word(input logic [TW-1:0] w, input int lane, input logic ins);
    logic [TW-1:0] x;
    x = w;
    if (ins) x[55:48] = 8'(lane);
    return x;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_lanes(input string nm);
    for (int i = 0; i < NL; i++) begin
      chk($sformatf("%s_lane%0d", nm, i), lane_ts_o[i*TW +: TW], exp_lane[i]);
    end
  endtask

  // Steps cycles until req_rdy is seen; the gap is counted from the caller's step
  task automatic wait_rdy(input int start_g, input int exp_gap, input string nm);
    int  g;
    bit  got;
    g   = start_g;
    got = 1'b0;
    while (!got && g < 100) begin
      @(negedge clk);
      #1;
      g++;
      if (req_rdy === 1'b1) got = 1'b1;
    end
    chk(nm, 128'(g), 128'(exp_gap));
  endtask

  task automatic note_accept();
    for (int i = 0; i < NL; i++) begin
      if (lane_en[i]) exp_lane[i] = lane_word(req_ts, i, lane_num_ins);
    end
    exp_cnt = (exp_cnt < CMAX) ? exp_cnt + 1 : CMAX;
  endtask

  task automatic finish_slot(input string nm, input logic [3:0] vld);
    @(negedge clk);
    #1;
    chk({nm, "_vld"}, 128'(lane_ts_o_vld), 128'(vld));
    chk({nm, "_cnt"}, 128'(ts_sent_cnt), 128'(exp_cnt));
    chk({nm, "_skp"}, 128'(skp_sent), 128'(0));
    chk_lanes(nm);
  endtask

  task automatic drive_vec(input int k);
    lane_en      = tv[k].len;
    lane_num_ins = tv[k].lni;
    req_ts       = {4{tv[k].seed}};
  endtask

  task automatic chk_reset_state(input string nm);
    for (int i = 0; i < NL; i++) exp_lane[i] = '0;
    exp_cnt = 0;
    chk({nm, "_vld"}, 128'(lane_ts_o_vld), 128'(0));
    chk({nm, "_cnt"}, 128'(ts_sent_cnt), 128'(0));
    chk({nm, "_rdy"}, 128'(req_rdy), 128'(0));
    chk({nm, "_skp"}, 128'(skp_sent), 128'(0));
    chk_lanes(nm);
  endtask

  // Randomized run: model tracks absolute issue times rather than a counter
  task automatic random_run(input int ncyc);
    bit       m_active;
    int       m_next;
    bit       prev_acc;
    bit       issue;
    bit       skp;
    bit       acc;
    logic [NL-1:0] e_vld;
    logic     e_skp;
`ifdef LTSSM_TS_SKP_EN
    int       m_issues;
    bit       m_pend;
    m_issues = 0;
    m_pend   = 1'b0;
`endif
    m_active = 1'b0;
    m_next   = 0;
    prev_acc = 1'b0;
    e_vld    = '0;
    e_skp    = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (!req_vld || prev_acc) begin
        req_vld = ($urandom_range(0, 3) != 0);
        req_ts  = {$urandom, $urandom, $urandom, $urandom};
      end
      if (sched_en) sched_en = ($urandom_range(0, 149) != 0);
      else          sched_en = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 29) == 0) rate = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) lane_en = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) lane_num_ins = ~lane_num_ins;
      ts_cnt_clr = ($urandom_range(0, 49) == 0);
      #1;
      chk("rnd_vld", 128'(lane_ts_o_vld), 128'(e_vld));
      chk("rnd_skp", 128'(skp_sent), 128'(e_skp));
      chk("rnd_cnt", 128'(ts_sent_cnt), 128'(exp_cnt));
      chk_lanes("rnd");

      issue = m_active && sched_en && (c == m_next);
`ifdef LTSSM_TS_SKP_EN
      skp = issue && m_pend;
`else
      skp = 1'b0;
`endif
      acc = issue && !skp && req_vld;
      chk("rnd_rdy", 128'(req_rdy), 128'(acc));

      for (int i = 0; i < NL; i++) begin
        if (lane_en[i] && skp) exp_lane[i] = skp_word;
        else if (lane_en[i] && acc) exp_lane[i] = lane_word(req_ts, i, lane_num_ins);
      end
      e_vld = (skp || acc) ? lane_en : '0;
      e_skp = skp;
      if (ts_cnt_clr) exp_cnt = 0;
      else if (acc && exp_cnt < CMAX) exp_cnt++;

      if (!m_active) begin
        if (sched_en) begin
          m_active = 1'b1;
          m_next   = c + period_of(rate);
        end
      end else if (!sched_en) begin
        m_active = 1'b0;
      end else if (issue) begin
        m_next = c + period_of(rate);
      end
`ifdef LTSSM_TS_SKP_EN
      if (issue) begin
        m_issues++;
        if (skp) m_pend = 1'b0;
        if (m_issues % (SKPI - 1) == 0) m_pend = 1'b1;
      end
`endif
      prev_acc = acc;
    end
  endtask

  initial begin
    skp_word = {{15{8'h1C}}, 8'hBC};
    tv[0] = '{3'd0, 4'hF,    1'b0, 32'hA5A5_0001, 64, 4'hF};
    tv[1] = '{3'd4, 4'hF,    1'b1, 32'h1234_5678, 4,  4'hF};
    tv[2] = '{3'd4, 4'b0101, 1'b1, 32'h0000_0000, 4,  4'b0101};
    tv[3] = '{3'd3, 4'h0,    1'b0, 32'hDEAD_BEEF, 8,  4'h0};
    tv[4] = '{3'd2, 4'b1010, 1'b1, 32'hCAFE_F00D, 16, 4'b1010};
    tv[5] = '{3'd7, 4'hF,    1'b0, 32'h0F0F_F0F0, 64, 4'hF};
    tv[6] = '{3'd1, 4'b0011, 1'b1, 32'h8765_4321, 32, 4'b0011};
    tv[7] = '{3'd4, 4'hF,    1'b1, 32'h5555_AAAA, 4,  4'hF};

    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_state("reset");
    @(negedge clk);
    rst = 1'b1;

    // Table vectors: each rate is set in the previous issue cycle
    @(negedge clk);
    drive_vec(0);
    rate     = tv[0].rate;
    req_vld  = 1'b1;
    sched_en = 1'b1;
    #1;
    chk("idle_rdy", 128'(req_rdy), 128'(0));
    for (int k = 0; k < 8; k++) begin
      wait_rdy((k == 0) ? 0 : 1, tv[k].gap, $sformatf("tbl%0d_gap", k));
      note_accept();
      if (k < 7) rate = tv[k+1].rate;
      finish_slot($sformatf("tbl%0d", k), tv[k].vld);
      if (k < 7) drive_vec(k + 1);
    end

    // Mid-slot rate switch 4 -> 1
    wait_rdy(1, 4, "pre_sw_gap");
    note_accept();
    finish_slot("pre_sw", 4'hF);
    @(negedge clk);
    #1;
    rate = 3'd1;
    wait_rdy(2, 4, "sw_old_gap");
    note_accept();
    finish_slot("sw_old", 4'hF);
    wait_rdy(1, 32, "sw_new_gap");
    note_accept();
    rate = 3'd4;
    finish_slot("sw_new", 4'hF);

    // Counter saturation, then clear colliding with an accept
    for (int s = 0; s < 5; s++) begin
      wait_rdy(1, 4, "sat_gap");
      req_ts = {$urandom, $urandom, $urandom, $urandom};
      note_accept();
      finish_slot($sformatf("sat%0d", s), 4'hF);
      req_ts = {4{32'h1111_2222}};
    end
    wait_rdy(1, 4, "clr_gap");
    ts_cnt_clr = 1'b1;
    note_accept();
    exp_cnt = 0;
    finish_slot("clr", 4'hF);
    ts_cnt_clr = 1'b0;
    wait_rdy(1, 4, "post_clr_gap");
    note_accept();
    rate = 3'd2;
    finish_slot("post_clr", 4'hF);

    // sched_en low with req_vld held: no slots at all
    sched_en = 1'b0;
    begin
      int nrdy;
      int nvld;
      nrdy = 0;
      nvld = 0;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        #1;
        if (req_rdy) nrdy++;
        if (lane_ts_o_vld != '0) nvld++;
      end
      chk("off_rdy_count", 128'(nrdy), 128'(0));
      chk("off_vld_count", 128'(nvld), 128'(0));
    end
    sched_en = 1'b1;
    wait_rdy(0, 16, "reenable_gap");
    note_accept();
    finish_slot("reenable", 4'hF);

    // Drop sched_en exactly on an issue cycle
    for (int g = 2; g < 16; g++) begin
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    sched_en = 1'b0;
    #1;
    chk("drop_issue_rdy", 128'(req_rdy), 128'(0));
    @(negedge clk);
    #1;
    chk("drop_issue_vld", 128'(lane_ts_o_vld), 128'(0));
    sched_en = 1'b1;
    wait_rdy(0, 16, "drop_reenable_gap");
    note_accept();
    finish_slot("drop_reenable", 4'hF);

    // Asynchronous reset mid-slot with a request pending
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_state("mid_rst");
    rate = 3'd3;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    wait_rdy(0, 8, "post_rst_gap");
    note_accept();
    finish_slot("post_rst", 4'hF);

`ifdef LTSSM_TS_SKP_EN
    // SKP takes the 4th issue slot; the held TS goes out on the next one
    @(negedge clk);
    rst = 1'b0;
    rate = 3'd4;
    lane_en = 4'hF;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    for (int i = 0; i < NL; i++) exp_lane[i] = '0;
    exp_cnt = 0;
    wait_rdy(0, 4, "skp_ts1_gap");
    note_accept();
    finish_slot("skp_ts1", 4'hF);
    for (int s = 2; s <= 3; s++) begin
      wait_rdy(1, 4, $sformatf("skp_ts%0d_gap", s));
      note_accept();
      finish_slot($sformatf("skp_ts%0d", s), 4'hF);
    end
    begin
      int nrdy;
      nrdy = 0;
      for (int g = 2; g <= 4; g++) begin
        @(negedge clk);
        #1;
        if (req_rdy) nrdy++;
      end
      chk("skp_slot_rdy", 128'(nrdy), 128'(0));
    end
    @(negedge clk);
    #1;
    for (int i = 0; i < NL; i++) exp_lane[i] = skp_word;
    chk("skp_vld", 128'(lane_ts_o_vld), 128'(4'hF));
    chk("skp_sent", 128'(skp_sent), 128'(1));
    chk("skp_cnt", 128'(ts_sent_cnt), 128'(exp_cnt));
    chk_lanes("skp");
    wait_rdy(1, 4, "skp_next_ts_gap");
    note_accept();
    finish_slot("skp_next_ts", 4'hF);
`endif

    // Randomized run from a fresh reset
    @(negedge clk);
    rst        = 1'b0;
    sched_en   = 1'b0;
    req_vld    = 1'b0;
    ts_cnt_clr = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_reset_state("rnd_rst");
    rst = 1'b1;
    random_run(4000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
